sdram_mport: RTL and testbench

Multi-port front end for the Wishbone SDRAM controller: arbitrates NPORTS PicoRV32-style native memory buses (CPU, video fetch, DMA) onto one pipelined Wishbone master. Each transaction is single-word, single-beat, with round-robin or fixed-priority grant and a watchdog timeout. Sits between the SoC bus fabric and `wbsdram`; pad SB_IO instantiation stays in the board-level wrapper.

---
 rtl/sdram_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/sdram_mport.sv | 155 +++++++++++++++
 tb/tb_sdram_mport.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the multi-port SDRAM front end: FSM encoding,
// arbitration mode constants and defaults.
package sdram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStb,
    StAck,
    StDone
  } state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Index width that stays legal for a single port.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: round-robin after last_grant, or fixed
// priority with port 0 highest.
module rr_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned MODE   = ARB_RR,
  localparam int unsigned IW    = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     last_grant,
  output logic [NPORTS-1:0] grant,
  output logic [IW-1:0]     grant_idx
);

  logic [NPORTS-1:0] higher;
  logic [NPORTS-1:0] masked;
  logic [NPORTS-1:0] pick;

  always_comb begin
    higher = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      higher[i] = (i > int'(last_grant));
    end
    masked = req & higher;
    // Requesters above last_grant win first; otherwise wrap to the lowest.
    pick = ((MODE == ARB_RR) && (|masked)) ? masked : req;

    grant_idx = '0;
    for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
      if (pick[i]) grant_idx = IW'(i);
    end

    grant = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      grant[i] = (|req) && (grant_idx == IW'(i));
    end
  end

endmodule

// File: rtl/sdram_mport.sv
// Arbitrates several native memory buses onto one pipelined Wishbone master,
// single-beat transfers with a watchdog that aborts stuck slaves.
module sdram_mport
  import sdram_pkg::*;
#(
  parameter int unsigned NPORTS   = 2,
  parameter int unsigned AW       = 19,
  parameter int unsigned ARB_MODE = ARB_RR,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORTS-1:0]      mem_valid,
  input  logic [4*NPORTS-1:0]    mem_wstrb,
  input  logic [32*NPORTS-1:0]   mem_addr,
  input  logic [32*NPORTS-1:0]   mem_wdata,
  output logic [NPORTS-1:0]      mem_ready,
  output logic [31:0]            mem_rdata,
  output logic [NPORTS-1:0]      timeout_err,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [AW-1:0]          wb_addr,
  output logic [31:0]            wb_odata,
  output logic [3:0]             wb_sel,
  input  logic                   wb_ack,
  input  logic                   wb_stall,
  input  logic [31:0]            wb_idata
);

  localparam int unsigned IW = idx_width(NPORTS);

  state_e            state;
  logic [NPORTS-1:0] gnt;
  logic [NPORTS-1:0] grant_q;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     gidx_q;
  logic [IW-1:0]     last_grant;
  logic [31:0]       wd_cnt;
  logic              expire;

  logic [AW-1:0]     sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;

  // Byte-lane bits and bits above the word address are not forwarded.
  logic unused_addr;
  assign unused_addr = ^mem_addr;

  rr_arbiter #(
    .NPORTS(NPORTS),
    .MODE  (ARB_MODE)
  ) u_arb (
    .req       (mem_valid),
    .last_grant(last_grant),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (gnt[i]) begin
        sel_addr  = mem_addr[i*32+2 +: AW];
        sel_wdata = mem_wdata[i*32 +: 32];
        sel_wstrb = mem_wstrb[i*4 +: 4];
      end
    end
  end

  assign expire = (TIMEOUT != 0) && ((wd_cnt + 32'd1) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      last_grant  <= IW'(NPORTS - 1);
      grant_q     <= '0;
      gidx_q      <= '0;
      wd_cnt      <= '0;
      mem_ready   <= '0;
      timeout_err <= '0;
      mem_rdata   <= '0;
      wb_cyc      <= 1'b0;
      wb_stb      <= 1'b0;
      wb_we       <= 1'b0;
      wb_addr     <= '0;
      wb_odata    <= '0;
      wb_sel      <= '0;
    end else begin
      mem_ready   <= '0;
      timeout_err <= '0;
      unique case (state)
        StIdle: begin
          if (|mem_valid) begin
            grant_q  <= gnt;
            gidx_q   <= gnt_idx;
            wb_addr  <= sel_addr;
            wb_odata <= sel_wdata;
            wb_we    <= |sel_wstrb;
            wb_sel   <= (|sel_wstrb) ? sel_wstrb : 4'hF;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wd_cnt   <= '0;
            state    <= StStb;
          end
        end
        StStb: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (!wb_stall && wb_ack) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            mem_rdata <= wb_idata;
            mem_ready <= grant_q;
            state     <= StDone;
          end else if (expire) begin
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            mem_rdata   <= ERR_DATA;
            mem_ready   <= grant_q;
            timeout_err <= grant_q;
            state       <= StDone;
          end else if (!wb_stall) begin
            wb_stb <= 1'b0;
            state  <= StAck;
          end
        end
        StAck: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (wb_ack) begin
            wb_cyc    <= 1'b0;
            mem_rdata <= wb_idata;
            mem_ready <= grant_q;
            state     <= StDone;
          end else if (expire) begin
            wb_cyc      <= 1'b0;
            mem_rdata   <= ERR_DATA;
            mem_ready   <= grant_q;
            timeout_err <= grant_q;
            state       <= StDone;
          end
        end
        StDone: begin
          // One dead cycle lets the master drop mem_valid before re-arbitration.
          last_grant <= gidx_q;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_mport.sv
// Directed bench for sdram_mport: 4-port round-robin instance with a
// behavioural Wishbone slave, plus a 2-port fixed-priority instance.
module tb_sdram_mport;
  localparam int NP = 4;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Main instance signals
  logic [NP-1:0]    mem_valid = '0;
  logic [4*NP-1:0]  mem_wstrb = '0;
  logic [32*NP-1:0] mem_addr  = '0;
  logic [32*NP-1:0] mem_wdata = '0;
  logic [NP-1:0]    mem_ready, timeout_err;
  logic [31:0]      mem_rdata;
  logic             wb_cyc, wb_stb, wb_we;
  logic [AW-1:0]    wb_addr;
  logic [31:0]      wb_odata;
  logic [3:0]       wb_sel;
  logic             wb_ack = 1'b0;
  logic             wb_stall = 1'b0;
  logic [31:0]      wb_idata = '0;

  sdram_mport #(
    .NPORTS  (NP),
    .AW      (AW),
    .ARB_MODE(0),
    .TIMEOUT (8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .timeout_err(timeout_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_odata   (wb_odata),
    .wb_sel     (wb_sel),
    .wb_ack     (wb_ack),
    .wb_stall   (wb_stall),
    .wb_idata   (wb_idata)
  );

  // Fixed-priority instance: slave acks in the accepting cycle, data = word address
  logic [1:0]    f_valid = '0;
  logic [7:0]    f_wstrb = '0;
  logic [63:0]   f_addr_in = {32'h0000_0080, 32'h0000_0040};
  logic [63:0]   f_wdata = '0;
  logic [1:0]    f_ready, f_tmo;
  logic [31:0]   f_rdata;
  logic          f_cyc, f_stb, f_we;
  logic [AW-1:0] f_addr;
  logic [31:0]   f_odata;
  logic [3:0]    f_sel;
  logic          f_ack, f_stall;
  logic [31:0]   f_idata;
  assign f_ack   = f_stb;
  assign f_stall = 1'b0;
  assign f_idata = {13'd0, f_addr};

  sdram_mport #(
    .NPORTS  (2),
    .AW      (AW),
    .ARB_MODE(1),
    .TIMEOUT (0)
  ) dut_f (
    .clk        (clk),
    .reset      (reset),
    .mem_valid  (f_valid),
    .mem_wstrb  (f_wstrb),
    .mem_addr   (f_addr_in),
    .mem_wdata  (f_wdata),
    .mem_ready  (f_ready),
    .mem_rdata  (f_rdata),
    .timeout_err(f_tmo),
    .wb_cyc     (f_cyc),
    .wb_stb     (f_stb),
    .wb_we      (f_we),
    .wb_addr    (f_addr),
    .wb_odata   (f_odata),
    .wb_sel     (f_sel),
    .wb_ack     (f_ack),
    .wb_stall   (f_stall),
    .wb_idata   (f_idata)
  );

  // Behavioural Wishbone slave, evaluated on the falling edge
  int stall_cycles = 0;
  int ack_lat = 1;
  int stall_cnt = 0;
  int ack_cnt = 0;
  logic [3:0] acc_addr = '0;
  logic [31:0] smem [16] = '{
    32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
    32'h12345678, 32'h10000005, 32'h10000006, 32'h10000007,
    32'h11223344, 32'h10000009, 32'h1000000A, 32'h1000000B,
    32'h1000000C, 32'h1000000D, 32'h1000000E, 32'h1000000F
  };

  always @(negedge clk) begin
    wb_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        wb_ack   = 1'b1;
        wb_idata = smem[acc_addr];
      end
    end
    if (wb_stb && stall_cnt < stall_cycles) begin
      wb_stall = 1'b1;
      stall_cnt++;
    end else begin
      wb_stall = 1'b0;
      if (!wb_stb) stall_cnt = 0;
    end
    if (wb_stb && !wb_stall) begin
      acc_addr = wb_addr[3:0];
      if (wb_we) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_sel[b]) smem[acc_addr][b*8 +: 8] = wb_odata[b*8 +: 8];
        end
      end
      if (ack_lat == 0) begin
        wb_ack   = 1'b1;
        wb_idata = smem[acc_addr];
      end else begin
        ack_cnt = ack_lat;
      end
    end
  end

  // One master transaction; lat is -1 if no mem_ready arrives within the budget.
  task automatic do_txn(input int port, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, output int lat, output int stb_n,
                        output int cyc_n, output logic [31:0] rdata, output logic [NP-1:0] rdy,
                        output logic [NP-1:0] tmo, output logic [AW-1:0] a, output logic we,
                        output logic [3:0] sel, output logic [31:0] od);
    int c0;
    bit seen;
    lat = -1; stb_n = 0; cyc_n = 0; rdata = '0; rdy = '0; tmo = '0;
    a = '0; we = 1'b0; sel = '0; od = '0; seen = 0;
    @(negedge clk);
    mem_addr[port*32 +: 32]  = addr;
    mem_wstrb[port*4 +: 4]   = strb;
    mem_wdata[port*32 +: 32] = data;
    mem_valid[port]          = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wb_stb) begin
        stb_n++;
        if (!seen) begin
          a = wb_addr; we = wb_we; sel = wb_sel; od = wb_odata; seen = 1;
        end
      end
      if (wb_cyc) cyc_n++;
      if (mem_ready != '0) begin
        lat = cyc - c0; rdy = mem_ready; tmo = timeout_err; rdata = mem_rdata;
        mem_valid[port] = 1'b0;
        break;
      end
    end
    mem_valid[port] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_ready !== 4'h0) begin errors++; $display("FAIL reset_ready got %h exp 0", mem_ready); end
    checks++; if (timeout_err !== 4'h0) begin errors++; $display("FAIL reset_tmo got %h exp 0", timeout_err); end
    checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b exp 000", {wb_cyc, wb_stb, wb_we}); end
    checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", wb_addr); end
    checks++; if (wb_odata !== 32'h0) begin errors++; $display("FAIL reset_odata got %h exp 0", wb_odata); end
    checks++; if (wb_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %h exp 0", wb_sel); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", mem_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int lat, sn, cn; logic [31:0] rd, od; logic [NP-1:0] rdy, tmo; logic [AW-1:0] a;
    logic we; logic [3:0] sel;
    stall_cycles = 0; ack_lat = 1;
    do_txn(0, 32'h0000_0010, 4'h0, 32'h0, lat, sn, cn, rd, rdy, tmo, a, we, sel, od);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    checks++; if (a !== 19'd4) begin errors++; $display("FAIL read_addr got %h exp 4", a); end
    checks++; if ({we, sel} !== 5'b0_1111) begin errors++; $display("FAIL read_we_sel got %b exp 01111", {we, sel}); end
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL read_ready got %b exp 0001", rdy); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL read_data got %h exp 12345678", rd); end
  endtask

  task automatic test_write_stall();
    int lat, sn, cn; logic [31:0] rd, od; logic [NP-1:0] rdy, tmo; logic [AW-1:0] a;
    logic we; logic [3:0] sel;
    stall_cycles = 3; ack_lat = 1;
    do_txn(1, 32'h0000_0020, 4'b0011, 32'hA5A5_5A5A, lat, sn, cn, rd, rdy, tmo, a, we, sel, od);
    checks++; if ({we, sel} !== 5'b1_0011) begin errors++; $display("FAIL write_we_sel got %b exp 10011", {we, sel}); end
    checks++; if (od !== 32'hA5A5_5A5A) begin errors++; $display("FAIL write_odata got %h exp a5a55a5a", od); end
    checks++; if (sn !== 4) begin errors++; $display("FAIL write_stb_cycles got %0d exp 4", sn); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL write_latency got %0d exp 6", lat); end
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL write_ready got %b exp 0010", rdy); end
    stall_cycles = 0;
    do_txn(1, 32'h0000_0020, 4'h0, 32'h0, lat, sn, cn, rd, rdy, tmo, a, we, sel, od);
    checks++; if (rd !== 32'h11225A5A) begin errors++; $display("FAIL write_readback got %h exp 11225a5a", rd); end
  endtask

  task automatic test_same_cycle_ack();
    int lat, sn, cn; logic [31:0] rd, od; logic [NP-1:0] rdy, tmo; logic [AW-1:0] a;
    logic we; logic [3:0] sel;
    stall_cycles = 0; ack_lat = 0;
    do_txn(2, 32'h0000_0014, 4'h0, 32'h0, lat, sn, cn, rd, rdy, tmo, a, we, sel, od);
    checks++; if (lat !== 2) begin errors++; $display("FAIL fast_ack_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'h10000005) begin errors++; $display("FAIL fast_ack_data got %h exp 10000005", rd); end
    ack_lat = 1;
  endtask

  task automatic test_timeout();
    int lat, sn, cn, late; logic [31:0] rd, od; logic [NP-1:0] rdy, tmo; logic [AW-1:0] a;
    logic we; logic [3:0] sel;
    stall_cycles = 0; ack_lat = 12;
    do_txn(2, 32'h0000_0018, 4'h0, 32'h0, lat, sn, cn, rd, rdy, tmo, a, we, sel, od);
    checks++; if (cn !== 8) begin errors++; $display("FAIL tmo_cyc_cycles got %0d exp 8", cn); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL tmo_latency got %0d exp 9", lat); end
    checks++; if ({rdy, tmo} !== 8'b0100_0100) begin errors++; $display("FAIL tmo_flags got %b exp 01000100", {rdy, tmo}); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_rdata got %h exp deadbeef", rd); end
    late = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready != '0 || wb_cyc) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL tmo_late_ack got %0d events exp 0", late); end
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_rdata_hold got %h exp deadbeef", mem_rdata); end
    ack_lat = 1;
  endtask

  // last_grant is 2 here, so round-robin over {0,1,3} starts at 3.
  task automatic test_rr_back_to_back();
    int exp_idx [6] = '{3, 0, 1, 3, 0, 1};
    int got_idx [6];
    int t [6];
    int n;
    n = 0;
    stall_cycles = 0; ack_lat = 1;
    @(negedge clk);
    mem_wstrb = '0;
    mem_addr = {32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
    mem_valid = 4'b1011;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge clk);
      if (mem_ready != '0) begin
        got_idx[n] = -1;
        for (int p = 0; p < NP; p++) if (mem_ready == (4'b0001 << p)) got_idx[n] = p;
        t[n] = cyc;
        n++;
        if (n == 6) mem_valid = '0;
      end
    end
    mem_valid = '0;
    checks++; if (n !== 6) begin errors++; $display("FAIL rr_count got %0d exp 6", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_idx[k] !== exp_idx[k]) begin
        errors++; $display("FAIL rr_grant_%0d got %0d exp %0d", k, got_idx[k], exp_idx[k]);
      end
      if (k > 0) begin
        checks++;
        if (t[k] - t[k-1] !== 4) begin
          errors++; $display("FAIL rr_interval_%0d got %0d exp 4", k, t[k] - t[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, sn, cn, stray; logic [31:0] rd, od; logic [NP-1:0] rdy, tmo; logic [AW-1:0] a;
    logic we; logic [3:0] sel;
    stall_cycles = 0; ack_lat = 12;
    @(negedge clk);
    mem_addr[3*32 +: 32] = 32'h0000_000C;
    mem_wstrb[3*4 +: 4]  = 4'h0;
    mem_valid[3] = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({wb_cyc, wb_stb} !== 2'b10) begin errors++; $display("FAIL mid_in_ack got %b exp 10", {wb_cyc, wb_stb}); end
    reset = 1'b1;
    mem_valid[3] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({wb_cyc, wb_stb} !== 2'b00) begin errors++; $display("FAIL mid_cyc_drop got %b exp 00", {wb_cyc, wb_stb}); end
    checks++; if (wb_addr !== '0) begin errors++; $display("FAIL mid_addr_clear got %h exp 0", wb_addr); end
    stray = (mem_ready != '0) ? 1 : 0;
    repeat (14) begin
      @(negedge clk);
      if (mem_ready != '0 || wb_cyc) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_no_ready got %0d events exp 0", stray); end
    ack_lat = 1;
    do_txn(3, 32'h0000_000C, 4'h0, 32'h0, lat, sn, cn, rd, rdy, tmo, a, we, sel, od);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mid_fresh_latency got %0d exp 3", lat); end
    checks++; if (rd !== 32'h10000003) begin errors++; $display("FAIL mid_fresh_data got %h exp 10000003", rd); end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] got [4];
    logic [31:0] dat [4];
    int t [4];
    int n;
    n = 0;
    @(negedge clk);
    f_valid = 2'b11;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (f_ready != '0) begin
        got[n] = f_ready; dat[n] = f_rdata; t[n] = cyc;
        n++;
        if (n == 4) f_valid = '0;
      end
    end
    f_valid = '0;
    checks++; if (n !== 4) begin errors++; $display("FAIL fixed_count got %0d exp 4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== 2'b01 || dat[k] !== 32'h10) begin
        errors++; $display("FAIL fixed_grant_%0d got %b/%h exp 01/00000010", k, got[k], dat[k]);
      end
      if (k > 0) begin
        checks++;
        if (t[k] - t[k-1] !== 3) begin
          errors++; $display("FAIL fixed_interval_%0d got %0d exp 3", k, t[k] - t[k-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_stall();
    test_same_cycle_ack();
    test_timeout();
    test_rr_back_to_back();
    test_reset_mid();
    test_fixed_priority();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
